// File: rtl/video_pkg.sv
// Shared timing defaults, counter widths and pixel type for the video timing generator.
package video_pkg;

   localparam int unsigned H_ACTIVE_DEF = 640;
   localparam int unsigned H_FP_DEF     = 16;
   localparam int unsigned H_SYNC_DEF   = 96;
   localparam int unsigned H_BP_DEF     = 48;
   localparam int unsigned V_ACTIVE_DEF = 480;
   localparam int unsigned V_FP_DEF     = 10;
   localparam int unsigned V_SYNC_DEF   = 2;
   localparam int unsigned V_BP_DEF     = 33;

   localparam int unsigned H_CNT_W = 11;
   localparam int unsigned V_CNT_W = 10;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } pixel_t;

   localparam pixel_t PIXEL_BLACK = '0;

   // Bar order left to right: white, yellow, cyan, green, magenta, red, blue, black.
   function automatic pixel_t bar_colour(input logic [2:0] idx);
      logic [2:0] w_on;
      case (idx)
         3'd0:    w_on = 3'b111;
         3'd1:    w_on = 3'b110;
         3'd2:    w_on = 3'b011;
         3'd3:    w_on = 3'b010;
         3'd4:    w_on = 3'b101;
         3'd5:    w_on = 3'b100;
         3'd6:    w_on = 3'b001;
         default: w_on = 3'b000;
      endcase
      return '{r: {8{w_on[2]}}, g: {8{w_on[1]}}, b: {8{w_on[0]}}};
   endfunction

endpackage

// File: rtl/video_counter.sv
// Free-running raster counters with combinational active/sync decode.
module video_counter
   import video_pkg::*;
#(
   parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
   parameter int unsigned H_FP     = H_FP_DEF,
   parameter int unsigned H_SYNC   = H_SYNC_DEF,
   parameter int unsigned H_BP     = H_BP_DEF,
   parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
   parameter int unsigned V_FP     = V_FP_DEF,
   parameter int unsigned V_SYNC   = V_SYNC_DEF,
   parameter int unsigned V_BP     = V_BP_DEF
) (
   input  logic               i_clock,
   input  logic               i_reset,
   output logic [H_CNT_W-1:0] o_h_cnt,
   output logic [V_CNT_W-1:0] o_v_cnt,
   output logic               o_active,
   output logic               o_hsync,
   output logic               o_vsync,
   output logic               o_origin
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [H_CNT_W-1:0] H_LAST   = H_CNT_W'(H_TOTAL - 1);
   localparam logic [H_CNT_W-1:0] H_ACT    = H_CNT_W'(H_ACTIVE);
   localparam logic [H_CNT_W-1:0] HS_BEG   = H_CNT_W'(H_ACTIVE + H_FP);
   localparam logic [H_CNT_W-1:0] HS_END   = H_CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [V_CNT_W-1:0] V_LAST   = V_CNT_W'(V_TOTAL - 1);
   localparam logic [V_CNT_W-1:0] V_ACT    = V_CNT_W'(V_ACTIVE);
   localparam logic [V_CNT_W-1:0] VS_BEG   = V_CNT_W'(V_ACTIVE + V_FP);
   localparam logic [V_CNT_W-1:0] VS_END   = V_CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   logic [H_CNT_W-1:0] r_h_cnt;
   logic [V_CNT_W-1:0] r_v_cnt;

   // Counters never stall: an underflowing upstream loses the pixel, not the raster.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (r_h_cnt == H_LAST) begin
         r_h_cnt <= '0;
         r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + V_CNT_W'(1);
      end else begin
         r_h_cnt <= r_h_cnt + H_CNT_W'(1);
      end
   end

   assign o_h_cnt  = r_h_cnt;
   assign o_v_cnt  = r_v_cnt;
   assign o_active = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
   assign o_hsync  = (r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END);
   assign o_vsync  = (r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END);
   assign o_origin = (r_h_cnt == '0) && (r_v_cnt == '0);

endmodule

// File: rtl/video_timing_gen.sv
// Video timing generator: paces an upstream 24-bit pixel stream onto a DVI raster.
// Define VIDEO_TESTPATTERN_EN to add the test_pattern colour-bar input.
module video_timing_gen
   import video_pkg::*;
#(
   parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
   parameter int unsigned H_FP     = H_FP_DEF,
   parameter int unsigned H_SYNC   = H_SYNC_DEF,
   parameter int unsigned H_BP     = H_BP_DEF,
   parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
   parameter int unsigned V_FP     = V_FP_DEF,
   parameter int unsigned V_SYNC   = V_SYNC_DEF,
   parameter int unsigned V_BP     = V_BP_DEF
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [23:0]        in_data,
   input  logic               in_sof,
`ifdef VIDEO_TESTPATTERN_EN
   input  logic               test_pattern,
`endif
   output logic               rgb_hs,
   output logic               rgb_vs,
   output logic               rgb_de,
   output logic [7:0]         rgb_r,
   output logic [7:0]         rgb_g,
   output logic [7:0]         rgb_b,
   output logic [H_CNT_W-1:0] pos_x,
   output logic [V_CNT_W-1:0] pos_y,
   output logic               frame_start,
   output logic               underflow,
   output logic               sync_error,
   input  logic               status_clear
);

   logic [H_CNT_W-1:0] w_h_cnt;
   logic [V_CNT_W-1:0] w_v_cnt;
   logic               w_active;
   logic               w_hsync;
   logic               w_vsync;
   logic               w_origin;
   logic               w_pattern_on;
   pixel_t             w_pattern_px;
   logic               w_accept;
   logic               w_uf_set;
   logic               w_se_set;
   pixel_t             w_next_px;

   logic               r_hs;
   logic               r_vs;
   logic               r_de;
   pixel_t             r_pixel;
   logic [H_CNT_W-1:0] r_pos_x;
   logic [V_CNT_W-1:0] r_pos_y;
   logic               r_frame_start;
   logic               r_underflow;
   logic               r_sync_error;

   video_counter #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP)
   ) u_counter (
      .i_clock  (clock),
      .i_reset  (reset),
      .o_h_cnt  (w_h_cnt),
      .o_v_cnt  (w_v_cnt),
      .o_active (w_active),
      .o_hsync  (w_hsync),
      .o_vsync  (w_vsync),
      .o_origin (w_origin)
   );

`ifdef VIDEO_TESTPATTERN_EN
   localparam int unsigned BAR_W = H_ACTIVE / 8;

   logic [2:0] w_bar_idx;

   always_comb begin
      w_bar_idx = '0;
      for (int unsigned i = 1; i < 8; i++) begin
         if (w_h_cnt >= H_CNT_W'(i * BAR_W)) w_bar_idx = 3'(i);
      end
   end

   assign w_pattern_on = test_pattern;
   assign w_pattern_px = bar_colour(w_bar_idx);
`else
   assign w_pattern_on = 1'b0;
   assign w_pattern_px = PIXEL_BLACK;
`endif

   assign in_ready = w_active && !reset && !w_pattern_on;
   assign w_accept = in_valid && in_ready;
   assign w_uf_set = w_active && !in_valid && !w_pattern_on;
   // A beat flagged SOF must land on the origin, and the origin beat must carry SOF.
   assign w_se_set = w_accept && (in_sof != w_origin);

   always_comb begin
      w_next_px = PIXEL_BLACK;
      if (w_active) begin
         if (w_pattern_on)  w_next_px = w_pattern_px;
         else if (w_accept) w_next_px = pixel_t'(in_data);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_hs          <= 1'b0;
         r_vs          <= 1'b0;
         r_de          <= 1'b0;
         r_pixel       <= PIXEL_BLACK;
         r_pos_x       <= '0;
         r_pos_y       <= '0;
         r_frame_start <= 1'b0;
         r_underflow   <= 1'b0;
         r_sync_error  <= 1'b0;
      end else begin
         r_hs          <= w_hsync;
         r_vs          <= w_vsync;
         r_de          <= w_active;
         r_pixel       <= w_next_px;
         r_pos_x       <= w_active ? w_h_cnt : '0;
         r_pos_y       <= w_active ? w_v_cnt : '0;
         r_frame_start <= w_active && w_origin;
         // Status is frozen while the bars are shown; a same-cycle set beats the clear.
         if (!w_pattern_on) begin
            r_underflow  <= w_uf_set || (r_underflow && !status_clear);
            r_sync_error <= w_se_set || (r_sync_error && !status_clear);
         end
      end
   end

   assign rgb_hs      = r_hs;
   assign rgb_vs      = r_vs;
   assign rgb_de      = r_de;
   assign rgb_r       = r_pixel.r;
   assign rgb_g       = r_pixel.g;
   assign rgb_b       = r_pixel.b;
   assign pos_x       = r_pos_x;
   assign pos_y       = r_pos_y;
   assign frame_start = r_frame_start;
   assign underflow   = r_underflow;
   assign sync_error  = r_sync_error;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a scaled 80x55 raster (64x48 active, hs 68..75, vs 50..51).
`timescale 1ns/1ps
module tb_video_timing_gen;

   localparam int HA = 64, HF = 4, HS = 8, HB = 4, HT = 80;
   localparam int VA = 48, VF = 2, VS = 2, VB = 3, VT = 55;

   localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_sof = 1'b0;
   logic [23:0] in_data = '0;
   logic        status_clear = 1'b0;
   logic        test_pattern = 1'b0;
   logic        in_ready;
   logic        rgb_hs, rgb_vs, rgb_de;
   logic [7:0]  rgb_r, rgb_g, rgb_b;
   logic [10:0] pos_x;
   logic [9:0]  pos_y;
   logic        frame_start, underflow, sync_error;

   video_timing_gen #(
      .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_sof       (in_sof),
`ifdef VIDEO_TESTPATTERN_EN
      .test_pattern (test_pattern),
`endif
      .rgb_hs       (rgb_hs),
      .rgb_vs       (rgb_vs),
      .rgb_de       (rgb_de),
      .rgb_r        (rgb_r),
      .rgb_g        (rgb_g),
      .rgb_b        (rgb_b),
      .pos_x        (pos_x),
      .pos_y        (pos_y),
      .frame_start  (frame_start),
      .underflow    (underflow),
      .sync_error   (sync_error),
      .status_clear (status_clear)
   );

   always #5 clock = ~clock;

   typedef struct {
      int          due;
      bit          chk;
      bit          cnt;
      logic        rdy;
      logic        hs, vs, de, fs, uf, se;
      logic [23:0] rgb;
      logic [10:0] px;
      logic [9:0]  py;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // Monitor: pops the expectation due this cycle and compares every output.
   exp_t mon_e;
   int   agg_de = 0, agg_fs = 0, agg_uf = 0, agg_hs_hi = 0, agg_hs_rise = 0;
   int   agg_vs_hi = 0, agg_vs_rise = 0;
   logic prev_hs = 1'b0, prev_vs = 1'b0;

   always @(negedge clock) begin
      while (q.size() > 0 && q[0].due <= cyc) begin
         mon_e = q.pop_front();
         if (mon_e.due != cyc) cmp("stale_expectation", mon_e.due, cyc);
         if (mon_e.chk) begin
            cmp("in_ready", in_ready, mon_e.rdy);
            cmp("rgb_hs", rgb_hs, mon_e.hs);
            cmp("rgb_vs", rgb_vs, mon_e.vs);
            cmp("rgb_de", rgb_de, mon_e.de);
            cmp("rgb", {rgb_r, rgb_g, rgb_b}, mon_e.rgb);
            cmp("pos_x", pos_x, mon_e.px);
            cmp("pos_y", pos_y, mon_e.py);
            cmp("frame_start", frame_start, mon_e.fs);
            cmp("underflow", underflow, mon_e.uf);
            cmp("sync_error", sync_error, mon_e.se);
         end
         if (mon_e.cnt) begin
            agg_de      += int'(rgb_de);
            agg_fs      += int'(frame_start);
            agg_uf      += int'(underflow);
            agg_hs_hi   += int'(rgb_hs);
            agg_vs_hi   += int'(rgb_vs);
            agg_hs_rise += int'(rgb_hs && !prev_hs);
            agg_vs_rise += int'(rgb_vs && !prev_vs);
            prev_hs = rgb_hs;
            prev_vs = rgb_vs;
         end
      end
   end

   // Reference model of the raster, driven alongside the stimulus.
   int   mh = 0, mv = 0;
   logic m_uf = 1'b0, m_se = 1'b0;
   exp_t pend;

   task automatic step(input bit rst, input bit vld, input bit sof, input bit clr,
                       input bit tp, input bit cw);
      exp_t it;
      bit   act, acc, org;
      reset        = rst;
      in_valid     = vld;
      in_sof       = sof;
      status_clear = clr;
      test_pattern = tp;
      in_data      = {8'(mh), 8'(mv), 8'h5A};
      act = (mh < HA) && (mv < VA);
      org = (mh == 0) && (mv == 0);
      it = pend;
      it.due = cyc;
      it.cnt = cw;
      it.rdy = act && !rst && !test_pattern;
      q.push_back(it);
      pend.chk = 1'b1;
      if (rst) begin
         pend.hs = 0; pend.vs = 0; pend.de = 0; pend.fs = 0; pend.uf = 0; pend.se = 0;
         pend.rgb = '0; pend.px = '0; pend.py = '0;
         m_uf = 0; m_se = 0; mh = 0; mv = 0;
      end else begin
         acc = vld && it.rdy;
         pend.hs = (mh >= 68) && (mh < 76);
         pend.vs = (mv >= 50) && (mv < 52);
         pend.de = act;
         pend.px = act ? 11'(mh) : '0;
         pend.py = act ? 10'(mv) : '0;
         pend.fs = act && org;
         if (tp && act) pend.rgb = BARS[mh / 8];
         else           pend.rgb = acc ? in_data : 24'h000000;
         if (!tp) begin
            m_uf = (act && !vld) || (m_uf && !clr);
            m_se = (acc && (sof != org)) || (m_se && !clr);
         end
         pend.uf = m_uf;
         pend.se = m_se;
         mh++;
         if (mh == HT) begin
            mh = 0;
            mv++;
            if (mv == VT) mv = 0;
         end
      end
      @(posedge clock);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      pend.chk = 1'b0;
      @(posedge clock);
      #1;
      repeat (3) step(1, 0, 0, 0, 0, 0);

      // Frame 1: clean stream, aggregate window over exactly one frame of output samples.
      for (int i = 0; i < HT * VT; i++)
         step(0, 1, (mh == 0 && mv == 0), 0, 0, 1);

      // Frame 2: 3-pixel underflow at (10,10), clears, and a set that coincides with a clear.
      for (int i = 0; i < HT * VT; i++)
         step(0,
              !((mv == 10 && mh >= 10 && mh <= 12) || (mv == 20 && mh == 30)),
              (mh == 0 && mv == 0),
              (mv == 12 && mh == 0) || (mv == 20 && mh == 30) || (mv == 30 && mh == 0),
              0, 0);

      // Frame 3: stray SOF on pixel (5,0), cleared on line 2.
      for (int i = 0; i < HT * VT; i++)
         step(0, 1, (mh == 0 && mv == 0) || (mh == 5 && mv == 0), (mv == 2 && mh == 0), 0, 0);

      // Frame 4: SOF missing at origin, then reset mid-frame at (32,24) for 2 cycles.
      while (!(mv == 24 && mh == 32))
         step(0, 1, 0, 0, 0, 0);
      repeat (2) step(1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 200; i++)
         step(0, 1, (mh == 0 && mv == 0), 0, 0, 0);

`ifdef VIDEO_TESTPATTERN_EN
      for (int i = 0; i < 2 * HT; i++)
         step(0, 1, 0, 0, 1, 0);
      for (int i = 0; i < 20; i++)
         step(0, 1, (mh == 0 && mv == 0), 0, 0, 0);
`endif

      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clock);
      #1;
      cmp("queue_drained", q.size(), 0);

      cmp("frame_de_cycles", agg_de, HA * VA);
      cmp("frame_hs_pulses", agg_hs_rise, VT);
      cmp("frame_hs_cycles", agg_hs_hi, VT * HS);
      cmp("frame_vs_pulses", agg_vs_rise, 1);
      cmp("frame_vs_cycles", agg_vs_hi, VS * HT);
      cmp("frame_start_count", agg_fs, 1);
      cmp("frame_underflow_cycles", agg_uf, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP 16, H_SYNC 96, H_BP 48; H_TOTAL = sum of H_ACTIVE, H_FP, H_SYNC and H_BP = 800.
REQ-003 SHALL have parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33; V_TOTAL = 525.
REQ-004 SHALL have port clock, input, 1 bit: the pixel clock; the only clock.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-006 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_data (input, 24, {r,g,b}) and in_sof (input, 1, first pixel of frame), forming the upstream pixel stream.
REQ-007 SHALL have ports rgb_hs, rgb_vs, rgb_de (outputs, 1 each, active-high) and rgb_r, rgb_g, rgb_b (outputs, 8 each), feeding the DVI transmitter.
REQ-008 SHALL have outputs pos_x (11 bits), pos_y (10 bits) and frame_start (1 bit).
REQ-009 SHALL have outputs underflow (1) and sync_error (1), both sticky, plus input status_clear (1).

Function
- REQ-010 SHALL keep counters h_cnt and v_cnt.
  - h_cnt wraps from H_TOTAL-1 to 0 every cycle.
  - v_cnt increments when h_cnt wraps, and wraps from V_TOTAL-1 to 0.
- REQ-011 SHALL compute active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- REQ-012 SHALL drive in_ready = active && !reset combinationally.
  - One beat is accepted per cycle in which in_valid && in_ready.
- REQ-013 SHALL register all rgb_*, pos_*, frame_start and status outputs, so every output reflects the counter state of the previous cycle (latency 1).
- REQ-014 SHALL assert rgb_hs when h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. 656..751.
- REQ-015 SHALL assert rgb_vs when v_cnt is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), i.e. 490..491.
- REQ-016 SHALL assert rgb_de exactly when active.
  - pos_x/pos_y equal h_cnt/v_cnt when active, else 0.
- REQ-017 SHALL pulse frame_start for one cycle, aligned with the output of pixel (0,0).
- REQ-018 SHALL present in_data on rgb_r/g/b for an accepted beat, and 0 when not active.
- REQ-019 SHALL treat active && !in_valid as underflow:
  - output black with rgb_de still 1;
  - set underflow;
  - consume no data;
  - leave the counters unaffected.
- REQ-020 SHALL set sync_error when an accepted beat has in_sof=1 at a position other than (0,0), or in_sof=0 at (0,0); the beat is still displayed.
- REQ-021 SHALL clear underflow and sync_error on status_clear.
  - If a new error occurs in the same cycle, the set wins.
- REQ-022 SHALL never assert in_ready during blanking; upstream holds its data.

Reset
- REQ-023 SHALL on reset set h_cnt = v_cnt = 0.
- REQ-024 SHALL on reset drive every output to 0 (hs, vs, de, rgb, pos, frame_start, underflow, sync_error).
- REQ-025 SHALL after reset deassertion begin at (0,0).
  - in_ready is 1 in the first cycle after reset.
  - frame_start is 1 in the second cycle after reset.
- REQ-026 SHALL on reset mid-frame abandon the frame without flushing; upstream must restart at in_sof.

Configuration
REQ-027 SHALL, when VIDEO_TESTPATTERN_EN is defined, add input test_pattern (1 bit).
- While test_pattern=1, in_ready is held 0 and underflow/sync_error do not update.
- Output is 8 vertical colour bars, each H_ACTIVE/8 wide. Order: white, yellow, cyan, green, magenta, red, blue, black. Components are 0x00 or 0xFF.
REQ-028 SHALL, without VIDEO_TESTPATTERN_EN, omit the test_pattern port and always use the stream.

Structure
REQ-029 SHALL place the default timing constants and the pixel type (struct of r, g, b bytes) in shared package video_pkg.
REQ-030 SHALL implement the h/v counters and sync decode in sub-module video_counter, instantiated once.

Verification
- REQ-031 Reset, then run 800*525 cycles with in_valid=1:
  - exactly 307200 de cycles;
  - 525 hs pulses of 96 cycles each;
  - one vs pulse of 1600 cycles;
  - frame_start once;
  - underflow=0.
- REQ-032 Feed in_data = {x[7:0], y[7:0], 8'h5A} with in_sof at (0,0):
  - every output pixel matches pos_x/pos_y;
  - the value appears one cycle after acceptance;
  - sync_error=0.
- REQ-033 Drop in_valid for 3 cycles at (100,10):
  - those 3 pixels are 0x000000 with rgb_de=1;
  - underflow=1;
  - status_clear then returns underflow to 0.
- REQ-034 Assert in_sof on pixel (5,0):
  - sync_error=1 one cycle later;
  - the pixel is still shown.
- REQ-035 Assert reset at (320,240) for 2 cycles:
  - outputs are 0 during reset;
  - in_ready=1 the first cycle after release;
  - frame_start fires one cycle later.
- REQ-036 With VIDEO_TESTPATTERN_EN and test_pattern=1:
  - in_ready=0 throughout;
  - the pixel at x=80 is 0xFFFF00 (yellow);
  - the pixel at x=639 is 0x000000.
